// File: rtl/dbs_pkg.sv
// Shared types for the door beam sequencer: FSM state encoding and filtered beam-pair codes.
package dbs_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      E1    = 3'd1,
      E2    = 3'd2,
      E3    = 3'd3,
      X1    = 3'd4,
      X2    = 3'd5,
      X3    = 3'd6,
      ABORT = 3'd7
   } dbs_state_e;

   // Beam pair codes are {A, B}
   localparam logic [1:0] B_NONE = 2'b00;
   localparam logic [1:0] B_A    = 2'b10;
   localparam logic [1:0] B_B    = 2'b01;
   localparam logic [1:0] B_BOTH = 2'b11;

endpackage

// File: rtl/beam_debounce.sv
// One beam input path: 2-flop synchroniser followed by a stable-sample debounce filter.
module beam_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic raw,
   output logic filt
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          filt_q, filt_d;
   logic          synced;

   assign synced = sync_q[1];
   assign filt   = filt_q;

   // Count consecutive synced samples that disagree with the filtered value; any agreeing
   // sample restarts the count.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (synced != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_d = synced;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync_q <= 2'b00;
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

endmodule

// File: rtl/door_beam_sequencer.sv
// Turns two door beams into IN/OUT/ERR event pulses by tracking the beam-break order.
// Optional feature: define DBS_ERR_COUNT_EN to add the saturating ERR_CNT abort counter.
module door_beam_sequencer
   import dbs_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 64,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic             BEAM_A,
   input  logic             BEAM_B,
   output logic             IN,
   output logic             OUT,
   output logic             ERR,
   output logic             BUSY
`ifdef DBS_ERR_COUNT_EN
   ,
   output logic [CNT_W-1:0] ERR_CNT
`endif
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic             filt_a, filt_b;
   logic [1:0]       ab;
   dbs_state_e       state_q, state_d;
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic             in_d, out_d, err_d;
   logic             tracking;

   beam_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_a (
      .clk (clk),
      .clr (CLR),
      .raw (BEAM_A),
      .filt(filt_a)
   );

   beam_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_b (
      .clk (clk),
      .clr (CLR),
      .raw (BEAM_B),
      .filt(filt_b)
   );

   assign ab       = {filt_a, filt_b};
   assign tracking = !(state_q inside {IDLE, ABORT});
   assign BUSY     = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      in_d    = 1'b0;
      out_d   = 1'b0;
      unique case (state_q)
         IDLE: case (ab)
            B_A:     state_d = E1;
            B_B:     state_d = X1;
            B_BOTH:  state_d = ABORT;
            default: ;
         endcase
         E1: case (ab)
            B_BOTH:  state_d = E2;
            B_NONE:  state_d = IDLE;
            B_B:     state_d = ABORT;
            default: ;
         endcase
         E2: case (ab)
            B_B:     state_d = E3;
            B_A:     state_d = E1;
            B_NONE:  state_d = ABORT;
            default: ;
         endcase
         E3: case (ab)
            B_NONE: begin
               state_d = IDLE;
               in_d    = 1'b1;
            end
            B_BOTH:  state_d = E2;
            B_A:     state_d = ABORT;
            default: ;
         endcase
         X1: case (ab)
            B_BOTH:  state_d = X2;
            B_NONE:  state_d = IDLE;
            B_A:     state_d = ABORT;
            default: ;
         endcase
         X2: case (ab)
            B_A:     state_d = X3;
            B_B:     state_d = X1;
            B_NONE:  state_d = ABORT;
            default: ;
         endcase
         X3: case (ab)
            B_NONE: begin
               state_d = IDLE;
               out_d   = 1'b1;
            end
            B_BOTH:  state_d = X2;
            B_B:     state_d = ABORT;
            default: ;
         endcase
         ABORT: begin
            if (ab == B_NONE) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Timeout only fires when the beams asked to stay put, so a real transition wins.
      if (tracking && (state_d == state_q) && (tmo_q == TMO_LAST)) state_d = ABORT;

      err_d = (state_d == ABORT) && (state_q != ABORT);
      tmo_d = (tracking && (state_d == state_q)) ? tmo_q + 1'b1 : '0;
   end

   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         state_q <= IDLE;
         tmo_q   <= '0;
         IN      <= 1'b0;
         OUT     <= 1'b0;
         ERR     <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         IN      <= in_d;
         OUT     <= out_d;
         ERR     <= err_d;
      end
   end

`ifdef DBS_ERR_COUNT_EN
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         ERR_CNT <= '0;
      end else if (err_d && (ERR_CNT != '1)) begin
         ERR_CNT <= ERR_CNT + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_door_beam_sequencer.sv
// Bench for door_beam_sequencer: directed scenarios plus randomized beam traffic against a
// behavioural occupancy-sensor model.
module tb_door_beam_sequencer;

   localparam int unsigned DB  = 4;
   localparam int unsigned TMO = 64;
   localparam int unsigned CW  = 8;

   logic clk    = 1'b0;
   logic CLR    = 1'b1;
   logic BEAM_A = 1'b0;
   logic BEAM_B = 1'b0;
   logic IN, OUT, ERR, BUSY;
`ifdef DBS_ERR_COUNT_EN
   logic [CW-1:0] ERR_CNT;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int n_in = 0, n_out = 0, n_err = 0;

   always #5 clk = ~clk;

   door_beam_sequencer #(
      .DEBOUNCE_CYCLES(DB),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (CW)
   ) dut (
      .clk   (clk),
      .CLR   (CLR),
      .BEAM_A(BEAM_A),
      .BEAM_B(BEAM_B),
      .IN    (IN),
      .OUT   (OUT),
      .ERR   (ERR),
      .BUSY  (BUSY)
`ifdef DBS_ERR_COUNT_EN
      ,
      .ERR_CNT(ERR_CNT)
`endif
   );

   // ---------------- behavioural model ----------------
   // Beam input: raw value seen two edges late, filtered flips once the last DB samples all
   // disagree with it. Direction: position 1..3 along the break order, dir +1 entry / -1 exit.
   bit          h1 [2];
   bit          h2 [2];
   bit          filt [2];
   bit [DB-1:0] win [2];
   int          mdir, mpos, dwell, e_errcnt;
   bit          mabort, e_in, e_out, e_err, abrt;
   logic [1:0]  mab;

   function automatic logic [1:0] step_code(int dir, int p);
      logic [1:0] c;
      case (p)
         1:       c = 2'b10;
         2:       c = 2'b11;
         default: c = 2'b01;
      endcase
      return (dir > 0) ? c : {c[0], c[1]};
   endfunction

   always @(posedge clk or posedge CLR) begin
      if (CLR) begin
         for (int i = 0; i < 2; i++) begin
            h1[i] = 0; h2[i] = 0; filt[i] = 0; win[i] = '0;
         end
         mdir = 0; mpos = 0; dwell = 0; mabort = 0; e_errcnt = 0;
         e_in = 0; e_out = 0; e_err = 0;
      end else begin
         mab = {filt[0], filt[1]};
         e_in = 0; e_out = 0; e_err = 0; abrt = 0;
         if (mabort) begin
            if (mab == 2'b00) mabort = 0;
         end else if (mdir == 0) begin
            if (mab == 2'b10) begin mdir = 1; mpos = 1; dwell = 0; end
            else if (mab == 2'b01) begin mdir = -1; mpos = 1; dwell = 0; end
            else if (mab == 2'b11) abrt = 1;
         end else begin
            if (mab == step_code(mdir, mpos)) begin
               if (dwell == TMO - 1) abrt = 1;
               else dwell++;
            end else if (mpos < 3 && mab == step_code(mdir, mpos + 1)) begin
               mpos++; dwell = 0;
            end else if (mpos > 1 && mab == step_code(mdir, mpos - 1)) begin
               mpos--; dwell = 0;
            end else if (mab == 2'b00 && mpos == 1) begin
               mdir = 0;
            end else if (mab == 2'b00 && mpos == 3) begin
               e_in = (mdir > 0); e_out = (mdir < 0); mdir = 0;
            end else begin
               abrt = 1;
            end
         end
         if (abrt) begin
            mabort = 1; mdir = 0; e_err = 1;
            if (e_errcnt < (1 << CW) - 1) e_errcnt++;
         end
         for (int i = 0; i < 2; i++) begin
            win[i] = {win[i][DB-2:0], h2[i]};
            if (win[i] == {DB{~filt[i]}}) filt[i] = ~filt[i];
            h2[i] = h1[i];
         end
         h1[0] = BEAM_A;
         h1[1] = BEAM_B;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      vectors++;
      if (IN !== e_in || OUT !== e_out || ERR !== e_err || BUSY !== (mabort || mdir != 0)) begin
         miscompares++;
         $display("FAIL cycle_check t=%0t IN/OUT/ERR/BUSY got %b%b%b%b want %b%b%b%b", $time,
                  IN, OUT, ERR, BUSY, e_in, e_out, e_err, (mabort || mdir != 0));
      end
`ifdef DBS_ERR_COUNT_EN
      vectors++;
      if (ERR_CNT !== CW'(e_errcnt)) begin
         miscompares++;
         $display("FAIL err_cnt t=%0t got %0d want %0d", $time, ERR_CNT, e_errcnt);
      end
`endif
      if (IN === 1'b1) n_in++;
      if (OUT === 1'b1) n_out++;
      if (ERR === 1'b1) n_err++;
   end

   // ---------------- helpers ----------------
   task automatic check(string name, int got, int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic hold(bit a, bit b, int n);
      BEAM_A = a;
      BEAM_B = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic hold_code(logic [1:0] c, int n);
      hold(c[1], c[0], n);
   endtask

   task automatic pulse_clr();
      #1 CLR = 1'b1;
      @(negedge clk);
      #1 CLR = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int i0, o0, e0, lat, width, busy_seen;
      repeat (3) @(negedge clk);
      check("reset_busy", int'(BUSY), 0);
      check("reset_pulses", int'(IN) + int'(OUT) + int'(ERR), 0);
      #1 CLR = 1'b0;
      repeat (4) @(negedge clk);

      // Entry: IN exactly 7 cycles after B falls, one cycle wide
      i0 = n_in; o0 = n_out; e0 = n_err;
      hold(1, 0, 8); hold(1, 1, 8); hold(0, 1, 8);
      BEAM_B = 0;
      lat = -1; width = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (IN === 1'b1) begin
            if (lat < 0) lat = k;
            width++;
         end
      end
      check("entry_latency", lat, 7);
      check("entry_width", width, 1);
      check("entry_in_count", n_in - i0, 1);
      check("entry_no_out_err", (n_out - o0) + (n_err - e0), 0);
      check("entry_busy_idle", int'(BUSY), 0);

      // Exit, then fifteen back-to-back exits
      o0 = n_out; i0 = n_in;
      hold(0, 1, 8); hold(1, 1, 8); hold(1, 0, 8); hold(0, 0, 12);
      check("exit_out_count", n_out - o0, 1);
      o0 = n_out;
      for (int k = 0; k < 15; k++) begin
         hold(0, 1, 8); hold(1, 1, 8); hold(1, 0, 8); hold(0, 0, 8);
      end
      hold(0, 0, 10);
      check("exit_burst_out_count", n_out - o0, 15);
      check("exit_no_in", n_in - i0, 0);

      // Back-out
      i0 = n_in; o0 = n_out; e0 = n_err;
      hold(1, 0, 8); hold(1, 1, 8);
      check("backout_busy_mid", int'(BUSY), 1);
      hold(1, 0, 8); hold(0, 0, 12);
      check("backout_no_pulse", (n_in - i0) + (n_out - o0) + (n_err - e0), 0);
      check("backout_idle", int'(BUSY), 0);

      // Short glitch on B
      e0 = n_err;
      hold(0, 1, 3);
      BEAM_B = 0;
      busy_seen = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (BUSY === 1'b1) busy_seen = 1;
      end
      check("glitch_busy", busy_seen, 0);
      check("glitch_no_err", n_err - e0, 0);

      // Timeout: E1 entered 7 cycles after A rises, ERR 64 cycles later
      e0 = n_err;
      BEAM_A = 1;
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (ERR === 1'b1 && lat < 0) lat = k;
      end
      check("timeout_latency", lat, 71);
      check("timeout_busy_held", int'(BUSY), 1);
      hold(0, 0, 12);
      check("timeout_busy_release", int'(BUSY), 0);
      check("timeout_err_count", n_err - e0, 1);
`ifdef DBS_ERR_COUNT_EN
      check("timeout_err_cnt", int'(ERR_CNT), 1);
`endif

      // Illegal jump: both beams in the same cycle
      i0 = n_in; e0 = n_err;
      hold(1, 1, 12);
      check("illegal_err", n_err - e0, 1);
      check("illegal_no_in", n_in - i0, 0);
      hold(0, 0, 12);

      // Reset while in E2, beams released during reset
      i0 = n_in; o0 = n_out; e0 = n_err;
      hold(1, 0, 8); hold(1, 1, 8);
      check("clr_busy_before", int'(BUSY), 1);
      #1 CLR = 1'b1;
      repeat (2) @(negedge clk);
      BEAM_A = 0; BEAM_B = 0;
      repeat (2) @(negedge clk);
      #1 CLR = 1'b0;
      repeat (20) @(negedge clk);
      check("clr_no_pulse", (n_in - i0) + (n_out - o0) + (n_err - e0), 0);
      check("clr_idle", int'(BUSY), 0);

      // Randomized traffic
      for (int it = 0; it < 300; it++) begin
         int r, dir;
         r = $urandom_range(0, 9);
         if (r <= 3) begin
            dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
            hold_code(step_code(dir, 1), $urandom_range(5, 14));
            hold_code(step_code(dir, 2), $urandom_range(5, 14));
            hold_code(step_code(dir, 3), $urandom_range(5, 14));
            if ($urandom_range(0, 3) == 0) begin
               hold_code(step_code(dir, 2), $urandom_range(5, 14));
               hold_code(step_code(dir, 3), $urandom_range(5, 14));
            end
            hold_code(2'b00, $urandom_range(5, 14));
         end else if (r <= 6) begin
            hold_code(2'($urandom_range(0, 3)), $urandom_range(1, 10));
         end else if (r == 7) begin
            hold_code(2'($urandom_range(1, 3)), $urandom_range(60, 80));
         end else if (r == 8) begin
            hold_code(2'b00, 12);
            hold_code(2'($urandom_range(1, 3)), $urandom_range(1, 3));
            hold_code(2'b00, 10);
         end else if ($urandom_range(0, 3) == 0) begin
            pulse_clr();
         end
      end
      hold(0, 0, 80);
      check("random_settles_idle", int'(BUSY), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
